// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down event/timer counter.
// Programmable modulo limit and step, count enable, wrap-or-saturate,
// combinational terminal count and registered overflow/underflow pulses.
module updown_counter_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic [WIDTH-1:0]  i_din,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic              i_sat,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_lim,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_tc,
  output logic              o_ovf,
  output logic              o_unf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH-1:0] w_wrap_up;
  logic [WIDTH-1:0] w_wrap_dn;
  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_ovf;
  logic             w_nxt_unf;

  // Zero-extend the step input to the counter width.
  always_comb begin
    w_step_ext               = '0;
    w_step_ext[STEP_W-1:0]   = i_step;
  end

  // Effective step is clamped to lim so a single step never wraps more than once.
  assign w_s     = (w_step_ext > i_lim) ? i_lim : w_step_ext;
  assign w_lim_x = {1'b0, i_lim};
  assign w_sum   = {1'b0, r_count} + {1'b0, w_s};

  // Wrap results are always below 2^WIDTH, so modular WIDTH-bit arithmetic
  // gives the same value as the full WIDTH+1-bit computation, including lim=2^WIDTH-1.
  assign w_wrap_up = w_sum[WIDTH-1:0] - i_lim - WIDTH'(1);
  assign w_wrap_dn = r_count + i_lim + WIDTH'(1) - w_s;

  // Next-state selection: load > out-of-range clamp > counting > hold.
  always_comb begin
    w_nxt_count = r_count;
    w_nxt_ovf   = 1'b0;
    w_nxt_unf   = 1'b0;
    if (i_ld) begin
      w_nxt_count = (i_din > i_lim) ? i_lim : i_din;
    end else if (i_en) begin
      if (r_count > i_lim) begin
        w_nxt_count = i_lim;
      end else if (i_mode) begin
        if (w_sum <= w_lim_x) begin
          w_nxt_count = w_sum[WIDTH-1:0];
        end else begin
          w_nxt_ovf   = 1'b1;
          w_nxt_count = i_sat ? i_lim : w_wrap_up;
        end
      end else begin
        if (r_count >= w_s) begin
          w_nxt_count = r_count - w_s;
        end else begin
          w_nxt_unf   = 1'b1;
          w_nxt_count = i_sat ? '0 : w_wrap_dn;
        end
      end
    end
  end

  // State registers with asynchronous clear; flags are one-cycle pulses.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_nxt_count;
      r_ovf   <= w_nxt_ovf;
      r_unf   <= w_nxt_unf;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;
  assign o_tc    = i_mode ? (r_count == i_lim) : (r_count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param (WIDTH=8, STEP_W=4).
module tb_updown_counter_param;

  logic       clk;
  logic       clr;
  logic       ld;
  logic [7:0] din;
  logic       en;
  logic       mode;
  logic       sat;
  logic [3:0] stp;
  logic [7:0] lim;
  logic [7:0] count;
  logic       tc;
  logic       ovf;
  logic       unf;

  updown_counter_param #(.WIDTH(8), .STEP_W(4)) dut (
    .i_clk(clk), .i_clr(clr), .i_ld(ld), .i_din(din), .i_en(en),
    .i_mode(mode), .i_sat(sat), .i_step(stp), .i_lim(lim),
    .o_count(count), .o_tc(tc), .o_ovf(ovf), .o_unf(unf)
  );

  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit tc;
  } exp_t;

  exp_t exp_q[$];
  int   m_count;
  int   n_total;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the arithmetic definition.
  task automatic model(input bit m_ld, input int m_din, input bit m_en, input bit m_mode,
                       input bit m_sat, input int m_stp, input int m_lim,
                       output int nc, output bit no, output bit nu);
    int s;
    s  = (m_stp < m_lim) ? m_stp : m_lim;
    nc = m_count;
    no = 0;
    nu = 0;
    if (m_ld) begin
      nc = (m_din < m_lim) ? m_din : m_lim;
    end else if (m_en) begin
      if (m_count > m_lim) nc = m_lim;
      else if (m_mode) begin
        if (m_count + s > m_lim) begin
          no = 1;
          nc = m_sat ? m_lim : (m_count + s) % (m_lim + 1);
        end else nc = m_count + s;
      end else begin
        if (m_count < s) begin
          nu = 1;
          nc = m_sat ? 0 : (m_count - s + m_lim + 1);
        end else nc = m_count - s;
      end
    end
  endtask

  // One clock: drive at negedge, push expectation, check after the rising edge.
  task automatic cyc(input bit c_ld, input int c_din, input bit c_en, input bit c_mode,
                     input bit c_sat, input int c_stp, input int c_lim);
    exp_t e;
    int   nc;
    bit   no, nu;
    @(negedge clk);
    ld = c_ld; din = 8'(c_din); en = c_en; mode = c_mode;
    sat = c_sat; stp = 4'(c_stp); lim = 8'(c_lim);
    model(c_ld, c_din, c_en, c_mode, c_sat, c_stp, c_lim, nc, no, nu);
    m_count = nc;
    e.cnt = nc; e.ovf = no; e.unf = nu;
    e.tc  = c_mode ? (nc == c_lim) : (nc == 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_count", int'(count), e.cnt);
      chk("sb_ovf", int'(ovf), int'(e.ovf));
      chk("sb_unf", int'(unf), int'(e.unf));
      chk("sb_tc", int'(tc), int'(e.tc));
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0; m_count = 0;
    clr = 1'b1; ld = 0; din = 0; en = 0; mode = 1; sat = 0; stp = 0; lim = 0;
    #3;
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    @(negedge clk);
    clr = 1'b0;

    // Async reset from count=37 with an ovf pulse pending.
    cyc(1, 37, 0, 1, 1, 1, 37);
    cyc(0, 0, 1, 1, 1, 1, 37);
    chk("pre_clr_cnt", int'(count), 37);
    chk("pre_clr_ovf", int'(ovf), 1);
    #2 clr = 1'b1;
    #1;
    chk("aclr_count", int'(count), 0);
    chk("aclr_ovf", int'(ovf), 0);
    chk("aclr_unf", int'(unf), 0);
    en = 1; mode = 1; stp = 4'd3; lim = 8'd200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("clr_hold", int'(count), 0);
    end
    @(negedge clk);
    clr = 1'b0;
    m_count = 0;

    // Load and clamp.
    cyc(1, 100, 0, 1, 0, 1, 200);  chk("ld_100", int'(count), 100);
    cyc(1, 250, 0, 1, 0, 1, 200);  chk("ld_clamp", int'(count), 200);
    cyc(1, 55, 1, 1, 0, 1, 200);   chk("ld_wins", int'(count), 55);

    // Up wrap.
    cyc(1, 8, 0, 1, 0, 1, 9);
    cyc(0, 0, 1, 1, 0, 1, 9);      chk("upw_9", int'(count), 9); chk("upw_tc", int'(tc), 1);
    cyc(0, 0, 1, 1, 0, 1, 9);      chk("upw_0", int'(count), 0); chk("upw_ovf", int'(ovf), 1);
    cyc(0, 0, 1, 1, 0, 1, 9);      chk("upw_1", int'(count), 1); chk("upw_ovf0", int'(ovf), 0);

    // Down wrap and saturate.
    cyc(1, 1, 0, 0, 0, 3, 9);
    cyc(0, 0, 1, 0, 0, 3, 9);      chk("dnw_8", int'(count), 8); chk("dnw_unf", int'(unf), 1);
    cyc(1, 1, 0, 0, 1, 3, 9);
    cyc(0, 0, 1, 0, 1, 3, 9);      chk("dns_0", int'(count), 0); chk("dns_unf", int'(unf), 1);
    cyc(0, 0, 1, 0, 1, 3, 9);      chk("dns_0b", int'(count), 0); chk("dns_unf2", int'(unf), 1);

    // Up saturate with step 7.
    cyc(1, 196, 0, 1, 1, 7, 200);
    cyc(0, 0, 1, 1, 1, 7, 200);    chk("ups_200", int'(count), 200); chk("ups_ovf", int'(ovf), 1);
    cyc(0, 0, 1, 1, 1, 7, 200);    chk("ups_200b", int'(count), 200); chk("ups_ovf2", int'(ovf), 1);
    cyc(0, 0, 0, 1, 1, 7, 200);    chk("ups_hold", int'(count), 200); chk("ups_ovf0", int'(ovf), 0);

    // Limit lowered below count, then lim=0.
    cyc(1, 120, 0, 1, 0, 1, 200);
    cyc(0, 0, 1, 1, 0, 1, 50);     chk("lim_50", int'(count), 50);
    chk("lim_noovf", int'(ovf), 0); chk("lim_nounf", int'(unf), 0);
    cyc(0, 0, 1, 1, 0, 1, 0);      chk("lim_0", int'(count), 0);
    @(negedge clk);
    mode = 0;
    #1 chk("lim0_tc_dn", int'(tc), 1);
    mode = 1;
    #1 chk("lim0_tc_up", int'(tc), 1);

    // Full-range wrap at lim=255.
    cyc(1, 250, 0, 1, 0, 15, 255);
    cyc(0, 0, 1, 1, 0, 15, 255);   chk("full_upw", int'(count), 9);
    cyc(0, 0, 1, 0, 0, 15, 255);   chk("full_dnw", int'(count), 250);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int rlim;
      rlim = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 60));
      cyc(($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)),
          ($urandom_range(0, 7) != 0), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rlim);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
